// File: rtl/sll_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential logical-left shifter.
// SLL_SEQ_FAST_EN selects a 4-bit shift step per cycle; otherwise the shifter moves 1 bit per cycle.
package sll_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 6;

`ifdef SLL_SEQ_FAST_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 1;
`endif

    localparam int STEP_W = $clog2(STEP + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Amounts of DATA_W or more all collapse to DATA_W: the result is zero and latency is fixed.
    function automatic logic [SHAMT_W-1:0] clamp_shamt(input logic [SHAMT_W-1:0] b);
        return (b > SHAMT_W'(DATA_W)) ? SHAMT_W'(DATA_W) : b;
    endfunction

    function automatic logic [STEP_W-1:0] step_of(input logic [SHAMT_W-1:0] cnt);
        return (cnt > SHAMT_W'(STEP)) ? STEP_W'(STEP) : cnt[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/sll_step.sv
// Combinational zero-filling left shift of a DATA_W word by 0..STEP bits.
// Step size follows STEP from sll_seq_pkg (SLL_SEQ_FAST_EN widens it).
module sll_step
    import sll_seq_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [STEP_W-1:0] amt,
    output logic [DATA_W-1:0] dout
);

    assign dout = din << amt;

endmodule

// File: rtl/sll_seq.sv
// Multi-cycle logical-left shifter: C = A << B, computed STEP bits per cycle by an IDLE/SHIFT/DONE FSM.
// Define SLL_SEQ_FAST_EN for 4 bits per cycle; the result is identical, only latency changes.
module sll_seq
    import sll_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [SHAMT_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] C
);

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [DATA_W-1:0]  work;
    logic [DATA_W-1:0]  work_shifted;
    logic [STEP_W-1:0]  step_amt;

    assign step_amt = step_of(cnt);

    sll_step u_step (
        .din  (work),
        .amt  (step_amt),
        .dout (work_shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            C     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= A;
                        cnt   <= clamp_shamt(B);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        C     <= work;
                        state <= DONE;
                    end else begin
                        work <= work_shifted;
                        cnt  <= cnt - SHAMT_W'(step_amt);
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here; requests are only taken from IDLE
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
